// File: rtl/tick_rate_if.sv
// Tick stream and decoded-speed outputs between the motor feedback tap and the decoder.
interface tick_rate_if #(
  parameter int CNT_W = 24
) ();
  logic             tick_in;
  logic [1:0]       spd_out;
  logic             spd_valid;
  logic [CNT_W-1:0] period_out;
  logic             err;

  modport master (
    output tick_in,
    input  spd_out,
    input  spd_valid,
    input  period_out,
    input  err
  );

  modport slave (
    input  tick_in,
    output spd_out,
    output spd_valid,
    output period_out,
    output err
  );
endinterface

// File: rtl/tick_rate_decoder.sv
// Recovers the 2-bit speed code from the tick period; a long tick-free interval reads as stopped.
//
// state   | meaning
// IDLE    | out of reset, no period reference yet
// ARMED   | measuring periods, waiting for two consecutive matching codes
// LOCKED  | spd_out confirmed, tracking the same code
// STOPPED | tick-free for TIMEOUT cycles, reports code 00 as valid
module tick_rate_decoder #(
  parameter int CNT_W     = 24,
  parameter int PERIOD_10 = 5000001,
  parameter int PERIOD_20 = 2500001,
  parameter int PERIOD_40 = 1250001,
  parameter int TOL       = 1000,
  parameter int TIMEOUT   = 10000002
) (
  input logic        clk,
  input logic        rst_n,
  tick_rate_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;
  localparam logic [1:0] S_STOPPED = 2'd3;

  // Two spare bits keep period and band limits free of wrap at the saturated count.
  localparam int PW = CNT_W + 2;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  localparam logic [PW-1:0] LO_40 = PW'((PERIOD_40 > TOL) ? PERIOD_40 - TOL : 0);
  localparam logic [PW-1:0] HI_40 = PW'(PERIOD_40 + TOL);
  localparam logic [PW-1:0] LO_20 = PW'((PERIOD_20 > TOL) ? PERIOD_20 - TOL : 0);
  localparam logic [PW-1:0] HI_20 = PW'(PERIOD_20 + TOL);
  localparam logic [PW-1:0] LO_10 = PW'((PERIOD_10 > TOL) ? PERIOD_10 - TOL : 0);
  localparam logic [PW-1:0] HI_10 = PW'(PERIOD_10 + TOL);

  logic             tick_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic [1:0]       cand;
  logic             cand_ok;

  logic             tick_edge;
  logic             timeout;
  logic [PW-1:0]    period;
  logic             match;
  logic [1:0]       code;

  assign tick_edge = bus.tick_in & ~tick_q;
  assign timeout   = (cnt == TIMEOUT_C);
  assign period    = PW'(cnt) + PW'(1);

  // Fastest code checked first so overlapping bands resolve toward the higher speed.
  always_comb begin
    match = 1'b1;
    code  = 2'b00;
    if (period >= LO_40 && period <= HI_40) begin
      code = 2'b11;
    end else if (period >= LO_20 && period <= HI_20) begin
      code = 2'b10;
    end else if (period >= LO_10 && period <= HI_10) begin
      code = 2'b01;
    end else begin
      match = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q         <= 1'b0;
      cnt            <= '0;
      state          <= S_IDLE;
      cand           <= 2'b00;
      cand_ok        <= 1'b0;
      bus.spd_out    <= 2'b00;
      bus.spd_valid  <= 1'b0;
      bus.period_out <= '0;
      bus.err        <= 1'b0;
    end else begin
      tick_q  <= bus.tick_in;
      bus.err <= 1'b0;

      if (tick_edge) begin
        cnt <= '0;
      end else if (!timeout) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (tick_edge) begin
            state   <= S_ARMED;
            cand_ok <= 1'b0;
          end else if (timeout) begin
            state         <= S_STOPPED;
            bus.spd_out   <= 2'b00;
            bus.spd_valid <= 1'b1;
          end
        end

        S_ARMED: begin
          if (tick_edge) begin
            bus.period_out <= period[CNT_W-1:0];
            if (match) begin
              if (cand_ok && cand == code) begin
                state         <= S_LOCKED;
                bus.spd_out   <= code;
                bus.spd_valid <= 1'b1;
              end else begin
                cand    <= code;
                cand_ok <= 1'b1;
              end
            end else begin
              bus.err <= 1'b1;
              cand_ok <= 1'b0;
            end
          end else if (timeout) begin
            state         <= S_STOPPED;
            bus.spd_out   <= 2'b00;
            bus.spd_valid <= 1'b1;
          end
        end

        S_LOCKED: begin
          if (tick_edge) begin
            bus.period_out <= period[CNT_W-1:0];
            if (match) begin
              // spd_out still carries the locked code; a different code re-arms with it as candidate.
              if (code != bus.spd_out) begin
                state         <= S_ARMED;
                cand          <= code;
                cand_ok       <= 1'b1;
                bus.spd_valid <= 1'b0;
              end
            end else begin
              bus.err       <= 1'b1;
              state         <= S_ARMED;
              cand_ok       <= 1'b0;
              bus.spd_valid <= 1'b0;
            end
          end else if (timeout) begin
            state         <= S_STOPPED;
            bus.spd_out   <= 2'b00;
            bus.spd_valid <= 1'b1;
          end
        end

        S_STOPPED: begin
          if (tick_edge) begin
            state         <= S_ARMED;
            cand_ok       <= 1'b0;
            bus.spd_valid <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tick_rate_decoder.md
# tick_rate_decoder

Recovers the 2-bit speed code from a speed-tick pulse stream, the inverse of the speed-to-tick generator that drives the elevator motor stepping logic. It measures the clock-cycle period between consecutive tick edges, matches it against the three nominal tick periods, and reports the decoded code once two consecutive periods agree. A long tick-free interval decodes as speed 00 (stopped). The block sits on the motor feedback side and lets the floor controller confirm the commanded speed.

## Interface

- CNT_W, 24, period counter width; must hold TIMEOUT
- PERIOD_10, 5000001, nominal clk cycles per tick for code 01 (10 Hz at 50 MHz)
- PERIOD_20, 2500001, nominal period for code 10 (20 Hz)
- PERIOD_40, 1250001, nominal period for code 11 (40 Hz)
- TOL, 1000, accepted deviation in cycles, inclusive
- TIMEOUT, 10000002, tick-free cycles before decoding 00
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- tick_in  input  1  tick stream, synchronous to clk; pulse or level-high of any length
- spd_out  output  2  decoded speed code
- spd_valid  output  1  spd_out is confirmed
- period_out  output  CNT_W  last measured period in cycles
- err  output  1  one-cycle pulse: measured period matched no code

## Operation

- Edge detect: edge = tick_in & ~tick_q, where tick_q is tick_in registered. A high level lasting several cycles is one edge.
- Counter: cnt clears to 0 on edge and otherwise increments, saturating at TIMEOUT.
- Measured period on an edge = cnt + 1. Edges N cycles apart give a period of N.
- Classification: a period P matches code c when |P − PERIOD_c| ≤ TOL.
  - Check order is 11, then 10, then 01; the first match wins.
  - Unsigned compare; no wrap.
- State machine: IDLE, ARMED, LOCKED, STOPPED. The block also holds cand (2 bits) and cand_ok (1 bit).
- IDLE (after reset):
  - On edge → ARMED, cand_ok=0. No classification.
  - On cnt==TIMEOUT without edge → STOPPED.
- ARMED, on edge:
  - period_out←P.
  - P matches c with cand_ok && cand==c → LOCKED, spd_out←c, spd_valid←1.
  - P matches c otherwise → cand←c, cand_ok←1, stay in ARMED.
  - No match → err pulse, cand_ok←0, stay in ARMED.
  - Timeout → STOPPED.
- LOCKED, on edge:
  - period_out←P.
  - Match with the same code → stay in LOCKED.
  - Match with a different code c → ARMED, cand←c, cand_ok←1, spd_valid←0. spd_out holds its old value.
  - No match → err, ARMED, cand_ok←0, spd_valid←0.
  - Timeout → STOPPED.
- STOPPED:
  - spd_out=00, spd_valid=1.
  - On edge → ARMED, cand_ok=0, spd_valid←0. No classification, since the period is meaningless after saturation.
- Simultaneous edge and cnt==TIMEOUT: the edge wins; the period is TIMEOUT+1, which is classified normally (normally no match → err).
- Reset mid-operation: all state and outputs clear immediately and asynchronously; the FSM returns to IDLE.

## Timing

- Reset values: spd_out=00, spd_valid=0, period_out=0, err=0, cnt=0, tick_q=0, state IDLE.
- All outputs are registered. Every output update takes effect on the clk edge that ends the cycle in which edge is high, so it is visible one cycle later.
- err is high for exactly one cycle per mismatched period.
- Lock latency from IDLE: third tick edge plus 1 cycle (two matching periods).
- STOPPED is entered TIMEOUT cycles after the last edge; outputs update 1 cycle later.
- Minimum edge spacing is 2 cycles, a consequence of edge detection.

## Test plan

Bench parameters: PERIOD_10=40, PERIOD_20=20, PERIOD_40=10, TOL=2, TIMEOUT=80, CNT_W=8.

1. Release reset, then 1-cycle ticks every 20 cycles → spd_out=10, spd_valid=1 one cycle after the 3rd edge; period_out=20; err never high.
2. Locked at 11 (period 10), then one period of 12, then one of 15 → period 12 stays LOCKED; period 15 gives a 1-cycle err pulse and spd_valid=0; the following periods of 10 relock after 2 periods.
3. From LOCKED 01, no ticks for 80 cycles → spd_out=00, spd_valid=1 at cycle 81. The next edge drops spd_valid. Periods of 10 then lock 11 after 2 more edges.
4. Locked at 01 (period 40), switch to period 20 → spd_valid=0 after the first 20-cycle period with spd_out still 01; spd_out=10, spd_valid=1 after the second.
5. tick_in held high for 5 cycles every 20 cycles → decodes identically to scenario 1.
6. rst_n pulled low mid-period while LOCKED → all outputs 0 within the same cycle, without a clk edge; after release, the behaviour of scenario 1 repeats.
